// File: rtl/aes_cbc_ctrl_pkg.sv
// Shared types and constants for the CBC encryption sequencer.
package aes_cbc_ctrl_pkg;

    localparam int AES_BLK_W = 128;
    localparam int CNT_W     = 4;

    // IDLE: no chain, LOADED: chain valid, CALC: datapath settling, OUT: result held
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_CALC   = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

    // Settle time must fit the 4-bit down-counter and be at least one cycle
    function automatic bit core_lat_legal(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/aes_cbc_ctrl.sv
// Multi-block CBC encryption sequencer. Owns key, IV/chain and block state,
// holds the external datapath inputs stable for CORE_LAT cycles, captures the
// ciphertext and chains it into the next block's IV.
module aes_cbc_ctrl
    import aes_cbc_ctrl_pkg::*;
#(
    parameter int CORE_LAT = 2,
    parameter int IDX_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [AES_BLK_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0] cfg_iv,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic [AES_BLK_W-1:0] pt_data,
    input  logic                 pt_last,
    output logic                 ct_valid,
    input  logic                 ct_ready,
    output logic [AES_BLK_W-1:0] ct_data,
    output logic                 ct_last,
    output logic [IDX_W-1:0]     ct_idx,
    output logic [AES_BLK_W-1:0] core_in,
    output logic [AES_BLK_W-1:0] core_iv,
    output logic [AES_BLK_W-1:0] core_key,
    input  logic [AES_BLK_W-1:0] core_out,
    output logic                 busy
);

    if (!core_lat_legal(CORE_LAT)) begin : g_bad_core_lat
        $error("aes_cbc_ctrl: CORE_LAT must be in 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);

    state_e                 state_q,    state_d;
    logic [AES_BLK_W-1:0]   key_q,      key_d;
    logic [AES_BLK_W-1:0]   chain_q,    chain_d;
    logic [AES_BLK_W-1:0]   pt_q,       pt_d;
    logic                   last_q,     last_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [AES_BLK_W-1:0]   ct_data_q,  ct_data_d;
    logic                   ct_last_q,  ct_last_d;
    logic                   ct_valid_q, ct_valid_d;
    logic [IDX_W-1:0]       ct_idx_q,   ct_idx_d;

    logic cfg_hs_s;
    logic pt_hs_s;
    logic ct_hs_s;

    // Config wins over a simultaneous plaintext offer in LOADED
    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_LOADED);
    assign pt_ready  = (state_q == ST_LOADED) && !cfg_valid;
    assign busy      = (state_q == ST_CALC) || (state_q == ST_OUT);

    assign cfg_hs_s  = cfg_valid && cfg_ready;
    assign pt_hs_s   = pt_valid && pt_ready;
    assign ct_hs_s   = ct_valid_q && ct_ready;

    assign core_in   = pt_q;
    assign core_iv   = chain_q;
    assign core_key  = key_q;
    assign ct_data   = ct_data_q;
    assign ct_last   = ct_last_q;
    assign ct_valid  = ct_valid_q;
    assign ct_idx    = ct_idx_q;

    // Next-state and register updates for the sequencer
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        chain_d    = chain_q;
        pt_d       = pt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        ct_data_d  = ct_data_q;
        ct_last_d  = ct_last_q;
        ct_valid_d = ct_valid_q;
        ct_idx_d   = ct_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_hs_s) begin
                    key_d    = cfg_key;
                    chain_d  = cfg_iv;
                    ct_idx_d = '0;
                    state_d  = ST_LOADED;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOADED: begin
                if (cfg_hs_s) begin
                    // message restart: fresh key and IV, index back to zero
                    key_d    = cfg_key;
                    chain_d  = cfg_iv;
                    ct_idx_d = '0;
                    state_d  = ST_LOADED;
                end else if (pt_hs_s) begin
                    pt_d     = pt_data;
                    last_d   = pt_last;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_LOADED;
                end
            end
            ST_CALC: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    ct_data_d  = core_out;
                    chain_d    = core_out;
                    ct_last_d  = last_q;
                    ct_valid_d = 1'b1;
                    state_d    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (ct_hs_s) begin
                    ct_valid_d = 1'b0;
                    if (ct_last_q) begin
                        // end of message: scrub key material, index holds
                        chain_d = '0;
                        key_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        ct_idx_d = ct_idx_q + IDX_W'(1);
                        state_d  = ST_LOADED;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ct_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            chain_q    <= '0;
            pt_q       <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            ct_data_q  <= '0;
            ct_last_q  <= 1'b0;
            ct_valid_q <= 1'b0;
            ct_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            chain_q    <= chain_d;
            pt_q       <= pt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            ct_data_q  <= ct_data_d;
            ct_last_q  <= ct_last_d;
            ct_valid_q <= ct_valid_d;
            ct_idx_q   <= ct_idx_d;
        end
    end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench for aes_cbc_ctrl. The external datapath is modelled by a
// table of known AES results with a keyed-permutation fallback for blocks
// outside the table.
module tb_aes_cbc_ctrl;

    localparam int CORE_LAT = 3;
    localparam int IDX_W    = 2;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] IVW = 128'hdeadbeef_01234567_89abcdef_cafef00d;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid, cfg_ready;
    logic [127:0]     cfg_key, cfg_iv;
    logic             pt_valid, pt_ready, pt_last;
    logic [127:0]     pt_data;
    logic             ct_valid, ct_ready, ct_last;
    logic [127:0]     ct_data;
    logic [IDX_W-1:0] ct_idx;
    logic [127:0]     core_in, core_iv, core_key, core_out;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    aes_cbc_ctrl #(.CORE_LAT(CORE_LAT), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
        .ct_idx(ct_idx),
        .core_in(core_in), .core_iv(core_iv), .core_key(core_key), .core_out(core_out),
        .busy(busy)
    );

    // Behavioural datapath: AES(key, pt ^ iv) for the known vectors
    function automatic logic [127:0] aes_model(input logic [127:0] x, input logic [127:0] key);
        if (key == K0 && x == PT0)        return CT0;
        if (key == K1 && x == (P1 ^ IV1)) return C1;
        if (key == K1 && x == (P2 ^ C1))  return C2;
        return {x[63:0], x[127:64]} ^ key ^ 128'h5a5a5a5a_0f0f0f0f_a5a5a5a5_f0f0f0f0;
    endfunction

    assign core_out = aes_model(core_in ^ core_iv, core_key);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic [127:0] key, input logic [127:0] iv);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_key = key; cfg_iv = iv;
        #1 chk("cfg_ready", cfg_ready, 1'b1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        chk("cfg_key_load", core_key, key);
        chk("cfg_iv_load", core_iv, iv);
        chk("cfg_idx_zero", ct_idx, 2'd0);
    endtask

    task automatic send_pt(input logic [127:0] pt, input logic last);
        int n;
        int lat;
        @(negedge clk);
        pt_valid = 1'b1; pt_data = pt; pt_last = last;
        n = 0;
        #1;
        while (!pt_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("pt_accept", pt_ready, 1'b1);
        @(posedge clk); #1;
        pt_valid = 1'b0;
        lat = 0;
        while (!ct_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, CORE_LAT);
    endtask

    task automatic recv_ct(input logic [127:0] exp, input logic last, input logic [IDX_W-1:0] idx);
        chk("ct_data", ct_data, exp);
        chk("ct_last", ct_last, last);
        chk("ct_idx", ct_idx, idx);
        @(negedge clk);
        ct_ready = 1'b1;
        @(posedge clk); #1;
        ct_ready = 1'b0;
        chk("ct_valid_drop", ct_valid, 1'b0);
    endtask

    task automatic watch_no_ct(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            seen = seen | ct_valid;
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] chain;
        logic [127:0] pt;
        logic [127:0] exp;

        rst = 1'b1; cfg_valid = 1'b0; cfg_key = '0; cfg_iv = '0;
        pt_valid = 1'b0; pt_data = '0; pt_last = 1'b0; ct_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_ct_valid", ct_valid, 1'b0);
        chk("rst_ct_last", ct_last, 1'b0);
        chk("rst_ct_data", ct_data, 128'd0);
        chk("rst_ct_idx", ct_idx, 2'd0);
        chk("rst_core_iv", core_iv, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_core_in", core_in, 128'd0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // plaintext offered in IDLE is never accepted
        pt_valid = 1'b1; pt_data = PT0;
        #1 chk("idle_pt_ready", pt_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("idle_no_busy", busy, 1'b0);
        pt_valid = 1'b0;

        // single FIPS-197 block
        do_cfg(K0, 128'd0);
        send_pt(PT0, 1'b1);
        chk("single_busy", busy, 1'b1);
        recv_ct(CT0, 1'b1, 2'd0);
        pt_valid = 1'b1;
        #1;
        chk("single_idle_cfg_ready", cfg_ready, 1'b1);
        chk("single_idle_pt_ready", pt_ready, 1'b0);
        chk("single_key_scrub", core_key, 128'd0);
        chk("single_chain_scrub", core_iv, 128'd0);
        chk("single_idx_hold", ct_idx, 2'd0);
        pt_valid = 1'b0;

        // SP800-38A CBC chaining
        do_cfg(K1, IV1);
        send_pt(P1, 1'b0);
        recv_ct(C1, 1'b0, 2'd0);
        chk("chain_iv", core_iv, C1);
        send_pt(P2, 1'b1);
        recv_ct(C2, 1'b1, 2'd1);

        // backpressure: result held, config ignored
        do_cfg(K1, IV1);
        send_pt(P1, 1'b0);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_key = K0; cfg_iv = 128'd0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_ct_data", ct_data, C1);
            chk("bp_ct_valid", ct_valid, 1'b1);
            chk("bp_pt_ready", pt_ready, 1'b0);
            chk("bp_cfg_ready", cfg_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        ct_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", ct_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_single_hs", ct_valid, 1'b0);
        chk("bp_idx_step", ct_idx, 2'd1);
        chk("bp_key_kept", core_key, K1);
        ct_ready = 1'b0;

        // simultaneous cfg and pt in LOADED: cfg wins, new IV used
        @(negedge clk);
        cfg_valid = 1'b1; cfg_key = K1; cfg_iv = IV1;
        pt_valid = 1'b1; pt_data = P1; pt_last = 1'b0;
        #1;
        chk("sim_pt_ready", pt_ready, 1'b0);
        chk("sim_cfg_ready", cfg_ready, 1'b1);
        @(posedge clk); #1;
        cfg_valid = 1'b0; pt_valid = 1'b0;
        chk("sim_new_iv", core_iv, IV1);
        chk("sim_idx", ct_idx, 2'd0);
        chk("sim_not_busy", busy, 1'b0);
        send_pt(P1, 1'b0);
        recv_ct(C1, 1'b0, 2'd0);

        // reset mid-CALC
        @(negedge clk);
        pt_valid = 1'b1; pt_data = P2; pt_last = 1'b1;
        @(posedge clk); #1;
        pt_valid = 1'b0;
        chk("calc_busy", busy, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("rcalc_ct_valid", ct_valid, 1'b0);
        chk("rcalc_core_iv", core_iv, 128'd0);
        chk("rcalc_busy", busy, 1'b0);
        chk("rcalc_cfg_ready", cfg_ready, 1'b1);
        watch_no_ct("rcalc_no_ct");

        // reset mid-OUT
        do_cfg(K0, 128'd0);
        send_pt(PT0, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("rout_ct_valid", ct_valid, 1'b0);
        chk("rout_core_iv", core_iv, 128'd0);
        chk("rout_busy", busy, 1'b0);
        watch_no_ct("rout_no_ct");

        // index wrap over five non-last blocks
        do_cfg(K0, IVW);
        chain = IVW;
        for (int i = 0; i < 5; i++) begin
            pt = {4{32'h1000_0000 + 32'(i)}};
            send_pt(pt, 1'b0);
            exp = aes_model(pt ^ chain, K0);
            recv_ct(exp, 1'b0, IDX_W'(i));
            chain = exp;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
